// File: rtl/psum_collector_pkg.sv
// Shared types for the psum collection path: the adder-tree beat tag and the
// collector FSM state encoding.
package psum_collector_pkg;

    // Beat tag carried alongside every partial sum from the adder trees.
    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        CNN_FIN = 2'd2,
        COMPL   = 2'd3
    } PE_STATE;

    // Collector control state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } COLLECT_STATE;

endpackage

// File: rtl/psum_fifo.sv
// Show-ahead result FIFO for psum_collector. Plain storage only: the caller
// decides what to push. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is ignored.
module psum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so data_out is clean after reset.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage write; contents need no reset because head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/psum_collector.sv
// psum_collector: reduces the adder-tree (status, data) beat stream into
// saturated output pixels, queues them, and hands them out over valid/ready.
// Optional macro PSUM_RELU_EN clamps negative results to zero before queueing.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int DATA_WID   = 8,
    parameter int ACC_WID    = 20,
    parameter int OUT_WID    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 status_in,
    input  logic signed [DATA_WID-1:0] data_in,
    output logic                       stall_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_WID-1:0]  data_out,
    output logic                       done,
    output logic                       overflow,
    output logic                       err_partial
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [ACC_WID-1:0] SAT_MAX =
        ACC_WID'((64'sd1 <<< (OUT_WID - 1)) - 64'sd1);
    localparam logic signed [ACC_WID-1:0] SAT_MIN =
        ACC_WID'(-(64'sd1 <<< (OUT_WID - 1)));

    COLLECT_STATE              state_q, state_d;
    PE_STATE                   status;
    logic signed [ACC_WID-1:0] acc_q, acc_d;
    logic signed [ACC_WID-1:0] data_ext, acc_sum, close_sum;
    logic signed [OUT_WID-1:0] sat_val, push_val;
    logic                      push, err_set, ovf_set, pop;
    logic                      fifo_full, fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [OUT_WID-1:0]        fifo_head;

    assign status   = PE_STATE'(status_in);
    assign data_ext = ACC_WID'(data_in);
    assign acc_sum  = acc_q + data_ext;
    // In IDLE a closing beat is a single-beat window: its sum is the beat itself.
    assign close_sum = (state_q == IDLE) ? data_ext : acc_sum;

    // Clamp the closing sum into the signed output range, then apply optional ReLU.
    always_comb begin
        sat_val = close_sum[OUT_WID-1:0];
        if (close_sum > SAT_MAX)      sat_val = SAT_MAX[OUT_WID-1:0];
        else if (close_sum < SAT_MIN) sat_val = SAT_MIN[OUT_WID-1:0];
        push_val = sat_val;
`ifdef PSUM_RELU_EN
        if (sat_val[OUT_WID-1]) push_val = '0;
`else
`endif
    end

    // Next-state, accumulator update and push decision.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        push    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                case (status)
                    VALID: begin
                        acc_d   = data_ext;
                        state_d = ACCUM;
                    end
                    CNN_FIN: push = 1'b1;
                    COMPL:   state_d = DRAIN;
                    default: ;
                endcase
            end
            ACCUM: begin
                case (status)
                    VALID: acc_d = acc_sum;
                    CNN_FIN: begin
                        push    = 1'b1;
                        acc_d   = '0;
                        state_d = IDLE;
                    end
                    COMPL: begin
                        err_set = 1'b1;
                        acc_d   = '0;
                        state_d = DRAIN;
                    end
                    default: ;
                endcase
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, accumulator and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            overflow    <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            overflow    <= overflow | ovf_set;
            err_partial <= err_partial | err_set;
        end
    end

    assign pop     = out_valid && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign ovf_set = push && fifo_full && !pop;

    psum_fifo #(
        .WIDTH (OUT_WID),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_val),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign out_valid = !fifo_empty;
    assign data_out  = fifo_head;
    assign stall_out = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector (default parameters).
module tb_psum_collector;
    import psum_collector_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        status_in = INVALID;
    logic signed [7:0] data_in = '0;
    logic              stall_out, out_valid, out_ready, done, overflow, err_partial;
    logic signed [7:0] data_out;

    int checks = 0;
    int errors = 0;
    int done_cnt;
    int valid_seen;
    logic signed [7:0] exp_neg;

    psum_collector dut (
        .clk         (clk),
        .reset       (reset),
        .status_in   (status_in),
        .data_in     (data_in),
        .stall_out   (stall_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .done        (done),
        .overflow    (overflow),
        .err_partial (err_partial)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input PE_STATE st, input logic signed [7:0] d);
        status_in = st;
        data_in   = d;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_data_out", {24'b0, data_out}, 32'd0);
        check("reset_stall", {31'b0, stall_out}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_flags", {30'b0, overflow, err_partial}, 32'd0);
        step();
        #2 reset = 1'b0;

        // Basic window: 10 - 3 + 5 = 12
        beat(VALID, 8'sd10);
        beat(VALID, -8'sd3);
        check("basic_not_early", {31'b0, out_valid}, 32'd0);
        beat(CNN_FIN, 8'sd5);
        check("basic_valid", {31'b0, out_valid}, 32'd1);
        check("basic_data", {24'b0, data_out}, {24'b0, 8'sd12});
        beat(INVALID, 8'sd0);
        check("basic_one_cycle", {31'b0, out_valid}, 32'd0);

        // Saturation high: 200 -> 127
        beat(VALID, 8'sd100);
        beat(CNN_FIN, 8'sd100);
        check("sat_hi_valid", {31'b0, out_valid}, 32'd1);
        check("sat_hi_data", {24'b0, data_out}, {24'b0, 8'sd127});
        beat(INVALID, 8'sd0);

        // Saturation low: -200 -> -128 (0 with ReLU)
`ifdef PSUM_RELU_EN
        exp_neg = 8'sd0;
`else
        exp_neg = -8'sd128;
`endif
        beat(VALID, -8'sd100);
        beat(CNN_FIN, -8'sd100);
        check("sat_lo_valid", {31'b0, out_valid}, 32'd1);
        check("sat_lo_data", {24'b0, data_out}, {24'b0, exp_neg});
        beat(INVALID, 8'sd0);
        check("sat_lo_popped", {31'b0, out_valid}, 32'd0);

        // Backpressure: five single-beat windows into a 4-deep FIFO
        out_ready = 1'b0;
        beat(CNN_FIN, 8'sd1);
        beat(CNN_FIN, 8'sd2);
        check("bp_stall_at_2", {31'b0, stall_out}, 32'd0);
        beat(CNN_FIN, 8'sd3);
        check("bp_stall_at_3", {31'b0, stall_out}, 32'd1);
        check("bp_no_ovf_yet", {31'b0, overflow}, 32'd0);
        beat(CNN_FIN, 8'sd4);
        check("bp_no_ovf_full", {31'b0, overflow}, 32'd0);
        beat(CNN_FIN, 8'sd5);
        check("bp_overflow", {31'b0, overflow}, 32'd1);
        beat(INVALID, 8'sd0);
        check("bp_head_held", {24'b0, data_out}, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("bp_pop_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp_pop_data_%0d", i), {24'b0, data_out}, i);
            step();
        end
        check("bp_drained", {31'b0, out_valid}, 32'd0);
        check("bp_stall_clear", {31'b0, stall_out}, 32'd0);
        check("bp_ovf_sticky", {31'b0, overflow}, 32'd1);

        // Layer end with a pending result
        out_ready = 1'b0;
        beat(CNN_FIN, 8'sd7);
        beat(COMPL, 8'sd0);
        status_in = INVALID;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_cnt++;
            step();
        end
        check("le_no_done_blocked", done_cnt, 32'd0);
        check("le_head", {24'b0, data_out}, 32'd7);
        out_ready = 1'b1;
        step();
        check("le_popped", {31'b0, out_valid}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            step();
        end
        check("le_done_once", done_cnt, 32'd1);
        check("le_err_partial", {31'b0, err_partial}, 32'd0);

        // Partial accumulation at COMPL
        beat(VALID, 8'sd4);
        beat(COMPL, 8'sd0);
        status_in = INVALID;
        done_cnt = 0;
        valid_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            if (out_valid) valid_seen++;
            step();
        end
        check("pc_err_partial", {31'b0, err_partial}, 32'd1);
        check("pc_no_push", valid_seen, 32'd0);
        check("pc_done_once", done_cnt, 32'd1);

        // Reset mid-operation
        out_ready = 1'b0;
        beat(CNN_FIN, 8'sd1);
        beat(CNN_FIN, 8'sd2);
        beat(VALID, 8'sd9);
        status_in = INVALID;
        check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", {31'b0, out_valid}, 32'd0);
        check("rst_async_data", {24'b0, data_out}, 32'd0);
        check("rst_async_flags", {28'b0, stall_out, done, overflow, err_partial}, 32'd0);
        step();
        #2 reset = 1'b0;
        out_ready = 1'b1;
        beat(CNN_FIN, 8'sd2);
        check("rst_post_valid", {31'b0, out_valid}, 32'd1);
        check("rst_post_data", {24'b0, data_out}, 32'd2);
        beat(INVALID, 8'sd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
